fpga_config_loader: RTL and testbench

// Streams one configuration frame into the FPGA fabric over a valid/ready word interface.

---
 rtl/fpga_config_loader_if.sv | 9 +
 rtl/fpga_config_loader.sv | 119 +++++++++++
 tb/tb_fpga_config_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_config_loader_if.sv
// rtl/fpga_config_loader_if.sv - word-stream handshake carrying configuration frames into the loader
interface fpga_config_loader_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - checked, atomic loader of one LUT/switch-box configuration frame
module fpga_config_loader #(
  parameter int          NUM_LUT  = 8,
  parameter int          LUT_BITS = 33,
  parameter int          NUM_SB   = 7,
  parameter int          SB_BITS  = 32,
  parameter logic [15:0] MAGIC    = 16'hC0F1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  fpga_config_loader_if.slave         cfg,
  output logic [NUM_LUT*LUT_BITS-1:0] lut_cfg,
  output logic [NUM_SB*SB_BITS-1:0]   sb_cfg,
  output logic                        fabric_en,
  output logic                        cfg_done,
  output logic                        cfg_error
);

  localparam int          P      = NUM_LUT + NUM_SB + 1;
  localparam int          IW     = $clog2(P);
  localparam logic [31:0] HEADER = {MAGIC, 16'(P)};
  localparam logic [IW-1:0] LAST = IW'(P - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, DONE, ERROR} state_t;

  state_t        state, state_next;
  logic          ready_q;
  logic [IW-1:0] cnt;
  logic [31:0]   acc;
  logic [31:0]   shadow [P];
  logic          accept;
  logic          is_header;
  logic          is_bad_header;

  assign cfg.cfg_ready  = ready_q && (state != COMMIT);
  assign accept         = cfg.cfg_valid && cfg.cfg_ready;
  assign is_header      = (cfg.cfg_data == HEADER);
  assign is_bad_header  = (cfg.cfg_data[31:16] == MAGIC) && !is_header;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (accept && is_header) begin
          state_next = LOAD;
        end else if (accept && is_bad_header) begin
          state_next = ERROR;
        end
      end
      LOAD:    if (accept && cnt == LAST) state_next = CHECK;
      CHECK:   if (accept) state_next = (cfg.cfg_data == acc) ? COMMIT : ERROR;
      COMMIT:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs only move in the COMMIT cycle, so a partial or rejected frame is never visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      lut_cfg   <= '0;
      sb_cfg    <= '0;
      fabric_en <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      for (int i = 0; i < P; i++) shadow[i] <= '0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        IDLE, DONE, ERROR: begin
          if (accept && is_header) begin
            cnt       <= '0;
            acc       <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            fabric_en <= 1'b0;
          end else if (accept && is_bad_header) begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b1;
            fabric_en <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            shadow[cnt] <= cfg.cfg_data;
            acc         <= acc ^ cfg.cfg_data;
            cnt         <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (accept && cfg.cfg_data != acc) cfg_error <= 1'b1;
        end
        COMMIT: begin
          // Extra-bit word is the last payload word; its MSB feeds LUT 0.
          for (int k = 0; k < NUM_LUT; k++) begin
            lut_cfg[k*LUT_BITS +: LUT_BITS] <= {shadow[P-1][31-k], shadow[k][LUT_BITS-2:0]};
          end
          for (int k = 0; k < NUM_SB; k++) begin
            sb_cfg[k*SB_BITS +: SB_BITS] <= shadow[NUM_LUT+k][SB_BITS-1:0];
          end
          fabric_en <= 1'b1;
          cfg_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - directed scoreboard bench for fpga_config_loader
module tb_fpga_config_loader;
  localparam int NUM_LUT  = 8;
  localparam int LUT_BITS = 33;
  localparam int NUM_SB   = 7;
  localparam int SB_BITS  = 32;
  localparam int LW       = NUM_LUT * LUT_BITS;
  localparam int SW       = NUM_SB * SB_BITS;

  typedef struct {
    logic [LW-1:0] lut;
    logic [SW-1:0] sb;
    logic          fen;
    logic          done;
    logic          err;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fpga_config_loader_if bus ();
  logic [LW-1:0] lut_cfg;
  logic [SW-1:0] sb_cfg;
  logic          fabric_en, cfg_done, cfg_error;

  fpga_config_loader #(
    .NUM_LUT(NUM_LUT), .LUT_BITS(LUT_BITS), .NUM_SB(NUM_SB), .SB_BITS(SB_BITS), .MAGIC(16'hC0F1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cfg(bus.slave),
    .lut_cfg(lut_cfg), .sb_cfg(sb_cfg),
    .fabric_en(fabric_en), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  int ncmp = 0;
  int nfail = 0;
  exp_t sbq[$];
  logic [31:0] lw [NUM_LUT];
  logic [31:0] sw [NUM_SB];
  logic [31:0] extra;
  logic [LW-1:0] model_lut;
  logic [SW-1:0] model_sb;
  logic mon_en = 1'b0;
  int   low_cnt = 0;

  always @(negedge clock) if (mon_en && !bus.cfg_ready) low_cnt++;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    int t;
    int gap;
    gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    bus.cfg_valid = 1'b0;
    repeat (gap) @(posedge clock);
    #1;
    bus.cfg_data  = w;
    bus.cfg_valid = 1'b1;
    t = 0;
    @(negedge clock);
    while (!bus.cfg_ready && t < 100) begin
      t++;
      @(negedge clock);
    end
    if (t >= 100) check("ready_timeout", LW'(bus.cfg_ready), LW'(1));
    @(posedge clock);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, "_queued"}, LW'(sbq.size() != 0), LW'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check({tag, "_lut"}, lut_cfg, e.lut);
      check({tag, "_sb"}, LW'(sb_cfg), LW'(e.sb));
      check({tag, "_fen"}, LW'(fabric_en), LW'(e.fen));
      check({tag, "_done"}, LW'(cfg_done), LW'(e.done));
      check({tag, "_err"}, LW'(cfg_error), LW'(e.err));
    end
  endtask

  task automatic send_frame(input string tag, input logic bad, input int maxgap);
    logic [31:0] cs;
    exp_t e;
    cs = 32'h0;
    send_word(32'hC0F1_0010, maxgap);
    for (int k = 0; k < NUM_LUT; k++) begin
      send_word(lw[k], maxgap);
      cs ^= lw[k];
    end
    for (int k = 0; k < NUM_SB; k++) begin
      send_word(sw[k], maxgap);
      cs ^= sw[k];
    end
    send_word(extra, maxgap);
    cs ^= extra;
    if (bad) begin
      cs ^= 32'h1;
      e = '{lut: model_lut, sb: model_sb, fen: 1'b0, done: 1'b0, err: 1'b1};
    end else begin
      for (int k = 0; k < NUM_LUT; k++) model_lut[k*LUT_BITS +: LUT_BITS] = {extra[31-k], lw[k]};
      for (int k = 0; k < NUM_SB; k++) model_sb[k*SB_BITS +: SB_BITS] = sw[k];
      e = '{lut: model_lut, sb: model_sb, fen: 1'b1, done: 1'b1, err: 1'b0};
    end
    sbq.push_back(e);
    send_word(cs, maxgap);
    if (!bad) begin
      check({tag, "_commit_ready"}, LW'(bus.cfg_ready), LW'(0));
      check({tag, "_commit_fen"}, LW'(fabric_en), LW'(0));
      @(posedge clock);
      #1;
      pop_compare(tag);
      check({tag, "_ready_back"}, LW'(bus.cfg_ready), LW'(1));
    end else begin
      pop_compare(tag);
    end
  endtask

  task automatic do_reset();
    #1;
    bus.cfg_valid = 1'b0;
    reset_n = 1'b0;
    model_lut = '0;
    model_sb = '0;
    @(negedge clock);
    check("rst_lut", lut_cfg, '0);
    check("rst_sb", LW'(sb_cfg), '0);
    check("rst_flags", LW'({fabric_en, cfg_done, cfg_error}), '0);
    check("rst_ready", LW'(bus.cfg_ready), '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rel_ready_low", LW'(bus.cfg_ready), '0);
    @(posedge clock);
    #1;
    check("rel_ready_high", LW'(bus.cfg_ready), LW'(1));
  endtask

  task automatic set_default();
    for (int k = 0; k < NUM_LUT; k++) lw[k] = 32'h1000_0000 + k;
    for (int k = 0; k < NUM_SB; k++) sw[k] = 32'hA5A5_0000 + k;
    extra = 32'hF000_0000;
  endtask

  task automatic set_frame_b();
    for (int k = 0; k < NUM_LUT; k++) lw[k] = 32'h0B00_0000 + 3 * k;
    for (int k = 0; k < NUM_SB; k++) sw[k] = 32'h5A5A_0000 | k;
    extra = 32'h5500_0000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_data  = '0;
    bus.cfg_valid = 1'b0;
    model_lut = '0;
    model_sb = '0;

    // 1: default frame
    do_reset();
    set_default();
    send_frame("t1", 1'b0, 0);
    check("t1_lut0_b32", LW'(lut_cfg[32]), LW'(1));
    check("t1_lut3_b32", LW'(lut_cfg[3*33+32]), LW'(1));
    check("t1_lut4_b32", LW'(lut_cfg[4*33+32]), LW'(0));
    check("t1_lut7_b32", LW'(lut_cfg[7*33+32]), LW'(0));
    check("t1_lut2_lo", LW'(lut_cfg[2*33 +: 32]), LW'(32'h1000_0002));
    check("t1_sb6", LW'(sb_cfg[6*32 +: 32]), LW'(32'hA5A5_0006));

    // 2: bad checksum from reset leaves outputs at zero
    do_reset();
    send_frame("t2", 1'b1, 0);
    check("t2_lut_zero", lut_cfg, '0);

    // 3: frame A, bad B, good B
    send_frame("t3a", 1'b0, 0);
    set_frame_b();
    send_frame("t3b_bad", 1'b1, 0);
    send_frame("t3b_good", 1'b0, 0);

    // 4: wrong magic ignored in IDLE, wrong count rejected
    do_reset();
    send_word(32'h1234_0010, 0);
    check("t4_magic_flags", LW'({fabric_en, cfg_done, cfg_error}), '0);
    send_word(32'hC0F1_000F, 0);
    check("t4_count_err", LW'(cfg_error), LW'(1));
    check("t4_count_fen", LW'(fabric_en), LW'(0));

    // 5: random valid gaps; ready low only in COMMIT
    set_default();
    low_cnt = 0;
    mon_en = 1'b1;
    send_frame("t5", 1'b0, 3);
    mon_en = 1'b0;
    check("t5_ready_low_cycles", LW'(low_cnt), LW'(1));

    // 6: reset mid-frame then a clean load
    send_word(32'hC0F1_0010, 0);
    for (int k = 0; k < 9; k++) send_word(32'hDEAD_0000 + k, 0);
    do_reset();
    set_frame_b();
    send_frame("t6", 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
